// File: rtl/meta_pkg.sv
// Shared definitions for the metadata streamer: FSM states, table layout,
// record command codes and the ROM image builder.
package meta_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StPoll,
      StDone
   } meta_state_e;

   localparam int unsigned MaxTables = 4;

   localparam logic [7:0] CmdDeviceName = 8'h01;
   localparam logic [7:0] CmdFwVersion  = 8'h02;
   localparam logic [7:0] CmdSampleMem  = 8'h21;
   localparam logic [7:0] CmdSampleRate = 8'h23;
   localparam logic [7:0] CmdProbeCount = 8'h40;
   localparam logic [7:0] CmdProtocol   = 8'h41;

   localparam logic [31:0] DeviceName = "MSTR";
   localparam logic [31:0] FwVersion  = "1.02";
   localparam logic [31:0] SampleMem  = 32'h0000_1000;
   localparam logic [31:0] SampleRate = 32'h05F5_E100;
   localparam logic [7:0]  ProbeCount = 8'h20;
   localparam logic [7:0]  Protocol   = 8'h02;
   localparam logic [31:0] TrigName   = "TRIG";
   localparam logic [7:0]  TrigStages = 8'h04;
   localparam logic [7:0]  TrigModes  = 8'h01;

   // Tables 2 and 3 are intentionally empty.
   localparam int unsigned TableBase [MaxTables] = '{0, 32, 0, 0};
   localparam int unsigned TableLen  [MaxTables] = '{27, 11, 0, 0};

   function automatic int unsigned table_base(int unsigned t);
      int unsigned r;
      case (t)
         0:       r = TableBase[0];
         1:       r = TableBase[1];
         2:       r = TableBase[2];
         3:       r = TableBase[3];
         default: r = 0;
      endcase
      return r;
   endfunction

   function automatic int unsigned table_len(int unsigned t);
      int unsigned r;
      case (t)
         0:       r = TableLen[0];
         1:       r = TableLen[1];
         2:       r = TableLen[2];
         3:       r = TableLen[3];
         default: r = 0;
      endcase
      return r;
   endfunction

   // Byte k of a 4-byte field, most significant first.
   function automatic logic [7:0] word_byte(logic [31:0] w, int unsigned k);
      return w[8*(3-k) +: 8];
   endfunction

   function automatic logic [7:0] table0_byte(int unsigned o);
      logic [7:0] b;
      if (o == 0)        b = CmdDeviceName;
      else if (o <= 4)   b = word_byte(DeviceName, o - 1);
      else if (o == 5)   b = 8'h00;
      else if (o == 6)   b = CmdFwVersion;
      else if (o <= 10)  b = word_byte(FwVersion, o - 7);
      else if (o == 11)  b = 8'h00;
      else if (o == 12)  b = CmdSampleMem;
      else if (o <= 16)  b = word_byte(SampleMem, o - 13);
      else if (o == 17)  b = CmdSampleRate;
      else if (o <= 21)  b = word_byte(SampleRate, o - 18);
      else if (o == 22)  b = CmdProbeCount;
      else if (o == 23)  b = ProbeCount;
      else if (o == 24)  b = CmdProtocol;
      else if (o == 25)  b = Protocol;
      else               b = 8'h00;
      return b;
   endfunction

   function automatic logic [7:0] table1_byte(int unsigned o);
      logic [7:0] b;
      if (o == 0)       b = CmdDeviceName;
      else if (o <= 4)  b = word_byte(TrigName, o - 1);
      else if (o == 5)  b = 8'h00;
      else if (o == 6)  b = CmdProbeCount;
      else if (o == 7)  b = TrigStages;
      else if (o == 8)  b = CmdProtocol;
      else if (o == 9)  b = TrigModes;
      else              b = 8'h00;
      return b;
   endfunction

   // Offsets wrap below a table's base, so a single unsigned compare bounds both ends.
   function automatic logic [7:0] rom_init(int unsigned a);
      int unsigned o0;
      int unsigned o1;
      logic [7:0]  b;
      o0 = a - TableBase[0];
      o1 = a - TableBase[1];
      b  = 8'h00;
      if (o0 < TableLen[0])      b = table0_byte(o0);
      else if (o1 < TableLen[1]) b = table1_byte(o1);
      return b;
   endfunction

endpackage

// File: rtl/meta_rom.sv
// Asynchronous-read metadata ROM; image comes from meta_pkg, unused words are zero.
module meta_rom
   import meta_pkg::*;
#(
   parameter int unsigned ROM_DEPTH  = 128,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic [$clog2(ROM_DEPTH)-1:0] addr_i,
   output logic [DATA_WIDTH-1:0]        data_o
);

   logic [DATA_WIDTH-1:0] mem [ROM_DEPTH];

   for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_word
      assign mem[i] = DATA_WIDTH'(rom_init($unsigned(i)));
   end

   assign data_o = mem[addr_i];

endmodule

// File: rtl/meta_streamer.sv
// Streams one selected metadata table to a transmitter, one word per handshake,
// with a guard window after each write before the transmitter's idle flag is trusted.
module meta_streamer
   import meta_pkg::*;
#(
   parameter int unsigned ROM_DEPTH    = 128,
   parameter int unsigned NUM_TABLES   = 2,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned GUARD_CYCLES = 1,
   localparam int unsigned TselW = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
   input  logic                  clock,
   input  logic                  extReset_n,
   input  logic                  query_metadata,
   input  logic [TselW-1:0]      table_sel,
   input  logic                  xmit_idle,
   input  logic                  abort,
   output logic                  writeMeta,
   output logic [DATA_WIDTH-1:0] meta_data,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned AddrW   = $clog2(ROM_DEPTH);
   localparam int unsigned IdxW    = AddrW + 1;
   localparam int unsigned NumChk  = (NUM_TABLES < MaxTables) ? NUM_TABLES : MaxTables;

   if (ROM_DEPTH < 64 || ROM_DEPTH > 1024 || (ROM_DEPTH & (ROM_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("meta_streamer: ROM_DEPTH must be a power of two in 64..1024");
   end
   if (NUM_TABLES < 1 || NUM_TABLES > MaxTables) begin : g_bad_tables
      $error("meta_streamer: NUM_TABLES must be 1..4");
   end
   if (GUARD_CYCLES > 3) begin : g_bad_guard
      $error("meta_streamer: GUARD_CYCLES must be 0..3");
   end
   for (genvar t = 0; t < NumChk; t++) begin : g_tbl_chk
      if (TableBase[t] + TableLen[t] > ROM_DEPTH) begin : g_overflow
         $error("meta_streamer: table %0d runs past the end of the ROM", t);
      end
   end

   function automatic logic [IdxW-1:0] tbl_len(logic [TselW-1:0] t);
      if (32'(t) >= NUM_TABLES) return '0;
      return IdxW'(table_len(32'(t)));
   endfunction

   function automatic logic [IdxW-1:0] tbl_base(logic [TselW-1:0] t);
      if (32'(t) >= NUM_TABLES) return '0;
      return IdxW'(table_base(32'(t)));
   endfunction

   meta_state_e      state_q, state_d;
   logic [TselW-1:0] tbl_q, tbl_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [1:0]       guard_q, guard_d;
   logic             pend_q, pend_d;

   logic [IdxW-1:0]       cur_len;
   logic [IdxW-1:0]       sel_len;
   logic [IdxW-1:0]       addr_full;
   logic [DATA_WIDTH-1:0] rom_data;

   assign cur_len   = tbl_len(tbl_q);
   assign sel_len   = tbl_len(table_sel);
   assign addr_full = tbl_base(tbl_q) + idx_q;

   meta_rom #(
      .ROM_DEPTH  (ROM_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rom (
      .addr_i (addr_full[AddrW-1:0]),
      .data_o (rom_data)
   );

   // One past the last word of a table ending at ROM_DEPTH must not alias address 0.
   assign meta_data = addr_full[AddrW] ? '0 : rom_data;

   always_comb begin
      state_d   = state_q;
      tbl_d     = tbl_q;
      idx_d     = idx_q;
      guard_d   = guard_q;
      pend_d    = pend_q;
      writeMeta = 1'b0;
      done      = 1'b0;
      busy      = (state_q != StIdle);

      if (state_q != StIdle && abort) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if ((query_metadata || pend_q) && xmit_idle) begin
                  tbl_d   = table_sel;
                  idx_d   = '0;
                  guard_d = '0;
                  pend_d  = 1'b0;
                  state_d = (sel_len == '0) ? StDone : StSend;
               end else if (query_metadata) begin
                  pend_d = 1'b1;
               end
            end
            StSend: begin
               writeMeta = 1'b1;
               idx_d     = idx_q + IdxW'(1);
               guard_d   = '0;
               state_d   = StPoll;
            end
            StPoll: begin
               if (guard_q != 2'(GUARD_CYCLES)) begin
                  guard_d = guard_q + 2'd1;
               end else if (xmit_idle) begin
                  state_d = (idx_q == cur_len) ? StDone : StSend;
               end
            end
            StDone: begin
               done    = 1'b1;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!extReset_n) begin
         state_q <= StIdle;
         tbl_q   <= '0;
         idx_q   <= '0;
         guard_q <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tbl_q   <= tbl_d;
         idx_q   <= idx_d;
         guard_q <= guard_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: tb/tb_meta_streamer.sv
// Bench for meta_streamer: directed scenarios plus random traffic, all checked
// against a transaction-level model of the stream timing and table contents.
module tb_meta_streamer;

   localparam int Guard = 1;

   logic       clock = 1'b0;
   logic       extReset_n;
   logic       query_metadata;
   logic [1:0] table_sel;
   logic       xmit_idle;
   logic       abort;
   logic       writeMeta;
   logic [7:0] meta_data;
   logic       busy;
   logic       done;

   always #5 clock = ~clock;

   meta_streamer #(
      .ROM_DEPTH    (128),
      .NUM_TABLES   (4),
      .DATA_WIDTH   (8),
      .GUARD_CYCLES (Guard)
   ) dut (
      .clock          (clock),
      .extReset_n     (extReset_n),
      .query_metadata (query_metadata),
      .table_sel      (table_sel),
      .xmit_idle      (xmit_idle),
      .abort          (abort),
      .writeMeta      (writeMeta),
      .meta_data      (meta_data),
      .busy           (busy),
      .done           (done)
   );

   // Expected table images: name "MSTR", version "1.02", 4096 samples, 100 MHz,
   // 32 probes, protocol 2; trigger table "TRIG", 4 stages, mode 1.
   logic [7:0] tbl0 [27] = '{8'h01, 8'h4D, 8'h53, 8'h54, 8'h52, 8'h00,
                             8'h02, 8'h31, 8'h2E, 8'h30, 8'h32, 8'h00,
                             8'h21, 8'h00, 8'h00, 8'h10, 8'h00,
                             8'h23, 8'h05, 8'hF5, 8'hE1, 8'h00,
                             8'h40, 8'h20, 8'h41, 8'h02, 8'h00};
   logic [7:0] tbl1 [11] = '{8'h01, 8'h54, 8'h52, 8'h49, 8'h47, 8'h00,
                             8'h40, 8'h04, 8'h41, 8'h01, 8'h00};

   function automatic int exp_len(int t);
      if (t == 0) return 27;
      if (t == 1) return 11;
      return 0;
   endfunction

   function automatic logic [7:0] exp_byte(int t, int i);
      if (t == 0 && i < 27) return tbl0[i];
      if (t == 1 && i < 11) return tbl1[i];
      return 8'h00;
   endfunction

   int         n_checks = 0;
   int         n_err    = 0;
   int         cyc      = 0;
   int         n_done   = 0;
   bit         chk_en   = 1'b0;
   logic [7:0] seen_bytes [$];
   int         seen_cyc   [$];

   // Model: stream in progress, strobe/done due this cycle, pending query.
   bit m_active, m_strobe, m_done, m_pend;
   int m_tbl, m_sent, m_ready_at;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_active));
         check("writeMeta", 32'(writeMeta), 32'(m_strobe && !abort));
         check("done", 32'(done), 32'(m_done && !abort));
         if (m_strobe && !abort)
            check("meta_data", 32'(meta_data), 32'(exp_byte(m_tbl, m_sent)));
      end
      if (writeMeta === 1'b1) begin
         seen_bytes.push_back(meta_data);
         seen_cyc.push_back(cyc);
      end
      if (done === 1'b1) n_done++;

      // Advance the model to what the coming edge must produce.
      if (extReset_n !== 1'b1) begin
         m_active = 0; m_strobe = 0; m_done = 0; m_pend = 0;
      end else if (m_active && abort) begin
         m_active = 0; m_strobe = 0; m_done = 0;
      end else if (!m_active) begin
         if ((query_metadata || m_pend) && xmit_idle) begin
            m_pend   = 0;
            m_tbl    = int'(table_sel);
            m_sent   = 0;
            m_active = 1;
            m_done   = (exp_len(m_tbl) == 0);
            m_strobe = !m_done;
         end else if (query_metadata) begin
            m_pend = 1;
         end
      end else if (m_done) begin
         m_active = 0;
         m_done   = 0;
      end else if (m_strobe) begin
         m_sent++;
         m_strobe   = 0;
         m_ready_at = cyc + 1 + Guard;
      end else if (cyc >= m_ready_at && xmit_idle) begin
         if (m_sent == exp_len(m_tbl)) m_done = 1;
         else m_strobe = 1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_query(input logic [1:0] sel);
      table_sel      = sel;
      query_metadata = 1'b1;
      tick();
      query_metadata = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int d0;
      int t;
      d0 = n_done;
      t  = 0;
      while (n_done == d0 && t < budget) begin
         tick();
         t++;
      end
      check({name, " done seen"}, 32'(n_done - d0), 32'd1);
   endtask

   task automatic wait_strobes(input int n, input int budget, input string name);
      int t;
      t = 0;
      while (seen_bytes.size() < n && t < budget) begin
         tick();
         t++;
      end
      check({name, " strobes reached"}, 32'(seen_bytes.size() >= n), 32'd1);
   endtask

   initial begin
      int d0;
      int rise;
      int bad;
      int seen;
      int lowcnt;

      extReset_n     = 1'b0;
      query_metadata = 1'b0;
      table_sel      = 2'd0;
      xmit_idle      = 1'b1;
      abort          = 1'b0;
      repeat (3) tick();
      extReset_n = 1'b1;
      chk_en     = 1'b1;
      #3;
      check("reset busy", 32'(busy), 32'd0);
      check("reset writeMeta", 32'(writeMeta), 32'd0);
      check("reset done", 32'(done), 32'd0);
      tick();

      // Full table 0 with the transmitter always ready.
      seen_bytes.delete(); seen_cyc.delete();
      d0 = n_done;
      pulse_query(2'd0);
      wait_done(200, "t0");
      repeat (5) tick();
      check("t0 single done", 32'(n_done - d0), 32'd1);
      check("t0 count", 32'(seen_bytes.size()), 32'd27);
      check("t0 first byte", 32'(seen_bytes[0]), 32'h01);
      check("t0 fw digit", 32'(seen_bytes[7]), 32'h31);
      check("t0 last byte", 32'(seen_bytes[26]), 32'h00);
      check("t0 spacing", 32'(seen_cyc[1] - seen_cyc[0]), 32'd3);
      check("t0 spacing tail", 32'(seen_cyc[26] - seen_cyc[25]), 32'd3);

      // Transmitter busy for 10 cycles after every strobe.
      seen_bytes.delete(); seen_cyc.delete();
      d0     = n_done;
      seen   = 0;
      lowcnt = 0;
      pulse_query(2'd0);
      for (int t = 0; t < 600 && n_done == d0; t++) begin
         if (seen_bytes.size() != seen) begin
            seen      = seen_bytes.size();
            xmit_idle = 1'b0;
            lowcnt    = 10;
         end else if (lowcnt > 0) begin
            lowcnt--;
            if (lowcnt == 0) xmit_idle = 1'b1;
         end
         tick();
      end
      xmit_idle = 1'b1;
      check("stall done seen", 32'(n_done - d0), 32'd1);
      check("stall count", 32'(seen_bytes.size()), 32'd27);
      check("stall gap", 32'(seen_cyc[1] - seen_cyc[0]), 32'd12);
      bad = 0;
      for (int i = 0; i < seen_bytes.size() && i < 27; i++)
         if (seen_bytes[i] !== tbl0[i]) bad++;
      check("stall order", 32'(bad), 32'd0);
      tick();

      // Query while transmitter busy is held; a mid-stream query is dropped.
      seen_bytes.delete(); seen_cyc.delete();
      d0        = n_done;
      xmit_idle = 1'b0;
      pulse_query(2'd0);
      repeat (4) tick();
      xmit_idle = 1'b1;
      rise      = cyc;
      wait_strobes(5, 100, "pend");
      check("pend start latency", 32'(seen_cyc[0] - rise), 32'd1);
      pulse_query(2'd1);
      wait_done(200, "pend");
      repeat (10) tick();
      check("pend no extra stream", 32'(seen_bytes.size()), 32'd27);
      check("pend one done", 32'(n_done - d0), 32'd1);

      // Abort after the 4th strobe, then restart from byte 0.
      seen_bytes.delete(); seen_cyc.delete();
      d0 = n_done;
      pulse_query(2'd0);
      wait_strobes(4, 100, "abort");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      #3;
      check("abort busy low", 32'(busy), 32'd0);
      repeat (20) tick();
      check("abort strobes", 32'(seen_bytes.size()), 32'd4);
      check("abort no done", 32'(n_done - d0), 32'd0);
      seen_bytes.delete(); seen_cyc.delete();
      pulse_query(2'd0);
      wait_done(200, "restart");
      check("restart first byte", 32'(seen_bytes[0]), 32'h01);
      check("restart count", 32'(seen_bytes.size()), 32'd27);
      tick();

      // Reset mid-stream, then table 1.
      seen_bytes.delete(); seen_cyc.delete();
      pulse_query(2'd0);
      wait_strobes(6, 100, "rst");
      extReset_n = 1'b0;
      tick();
      extReset_n = 1'b1;
      #3;
      check("rst busy", 32'(busy), 32'd0);
      check("rst writeMeta", 32'(writeMeta), 32'd0);
      check("rst done", 32'(done), 32'd0);
      repeat (8) tick();
      check("rst no more strobes", 32'(seen_bytes.size()), 32'd6);
      seen_bytes.delete(); seen_cyc.delete();
      pulse_query(2'd1);
      wait_done(100, "t1");
      check("t1 count", 32'(seen_bytes.size()), 32'd11);
      check("t1 name byte", 32'(seen_bytes[1]), 32'h54);
      check("t1 last byte", 32'(seen_bytes[10]), 32'h00);
      tick();

      // Empty table: done right after acceptance, no strobes.
      seen_bytes.delete(); seen_cyc.delete();
      pulse_query(2'd2);
      #3;
      check("len0 done", 32'(done), 32'd1);
      repeat (4) tick();
      check("len0 strobes", 32'(seen_bytes.size()), 32'd0);

      // Random traffic under the model.
      for (int i = 0; i < 3000; i++) begin
         query_metadata = ($urandom_range(0, 7) == 0);
         table_sel      = 2'($urandom_range(0, 3));
         xmit_idle      = ($urandom_range(0, 3) != 0);
         abort          = ($urandom_range(0, 63) == 0);
         extReset_n     = ($urandom_range(0, 499) != 0);
         tick();
      end
      query_metadata = 1'b0;
      abort          = 1'b0;
      extReset_n     = 1'b1;
      xmit_idle      = 1'b1;
      repeat (100) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
